alu_reservation_station: RTL and testbench

Reservation station directly upstream of the ALU issue/execute stage. It accepts dispatched ALU ops, holds them until both operands are available, and captures operand values broadcast on the common data bus (CDB). It selects the oldest ready entry into a registered issue slot that drives the execute stage's reservationStation* inputs, and obeys the execute stage's stall.

---
 rtl/alu_reservation_station.sv | 196 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : alu_reservation_station
// Brief    : ALU reservation station: CDB operand capture, oldest-ready issue
//            into a registered slot. Macro RS_CDB_WAKEUP_EN lets entries woken
//            on the CDB this cycle be selected with the CDB value forwarded.
// Revision : 1.0
// ============================================================================
module alu_reservation_station #(
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RS_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  dispatchValid_i,
    input  logic [9:0]            dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchDestTag_i,
    input  logic [63:0]           dispatchVal1_i,
    input  logic [63:0]           dispatchVal2_i,
    input  logic [ROBsizeLog-1:0] dispatchSrcTag1_i,
    input  logic [ROBsizeLog-1:0] dispatchSrcTag2_i,
    output logic                  rsFull_o,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [63:0]           cdbVal_i,
    input  logic                  stallRS_i,
    output logic [63:0]           reservationStationVal1_o,
    output logic [63:0]           reservationStationVal2_o,
    output logic [9:0]            reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    output logic                  readyRS_o
);
    localparam int c_age_w = $clog2(RS_DEPTH);
    localparam int c_idx_w = $clog2(RS_DEPTH);
    localparam logic [c_age_w-1:0] c_age_max = '1;

    logic [RS_DEPTH-1:0]   valid_q, valid_d;
    logic [c_age_w-1:0]    age_q  [RS_DEPTH];
    logic [c_age_w-1:0]    age_d  [RS_DEPTH];
    logic [9:0]            cmd_q  [RS_DEPTH];
    logic [9:0]            cmd_d  [RS_DEPTH];
    logic [ROBsizeLog-1:0] dest_q [RS_DEPTH];
    logic [ROBsizeLog-1:0] dest_d [RS_DEPTH];
    logic [ROBsizeLog-1:0] tag1_q [RS_DEPTH];
    logic [ROBsizeLog-1:0] tag1_d [RS_DEPTH];
    logic [ROBsizeLog-1:0] tag2_q [RS_DEPTH];
    logic [ROBsizeLog-1:0] tag2_d [RS_DEPTH];
    logic [63:0]           val1_q [RS_DEPTH];
    logic [63:0]           val1_d [RS_DEPTH];
    logic [63:0]           val2_q [RS_DEPTH];
    logic [63:0]           val2_d [RS_DEPTH];

    logic                  slotValid_q;
    logic [63:0]           slotVal1_q, slotVal2_q;
    logic [9:0]            slotCmd_q;
    logic [ROBsizeLog-1:0] slotTag_q;

    logic [RS_DEPTH-1:0]   w_hit1, w_hit2, w_ready;
    logic [63:0]           w_fwd1 [RS_DEPTH];
    logic [63:0]           w_fwd2 [RS_DEPTH];
    logic                  w_anyReady, w_freeFound, w_dispatch, w_load;
    logic [c_idx_w-1:0]    w_selIdx, w_freeIdx;
    logic [c_age_w-1:0]    w_selAge;

    // Per-entry CDB match and readiness; w_fwd* is the value as seen after capture.
    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
        assign w_hit1[i] = valid_q[i] && cdbValid_i && (tag1_q[i] != '0) && (tag1_q[i] == cdbTag_i);
        assign w_hit2[i] = valid_q[i] && cdbValid_i && (tag2_q[i] != '0) && (tag2_q[i] == cdbTag_i);
        assign w_fwd1[i] = w_hit1[i] ? cdbVal_i : val1_q[i];
        assign w_fwd2[i] = w_hit2[i] ? cdbVal_i : val2_q[i];
`ifdef RS_CDB_WAKEUP_EN
        assign w_ready[i] = valid_q[i] && ((tag1_q[i] == '0) || w_hit1[i])
                                       && ((tag2_q[i] == '0) || w_hit2[i]);
`else
        assign w_ready[i] = valid_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
`endif
    end

    assign rsFull_o   = &valid_q;
    assign w_load     = !slotValid_q || !stallRS_i;
    assign w_dispatch = dispatchValid_i && w_freeFound && !flush_i;

    // Oldest ready entry (strict > keeps the lower index on ties) and lowest free entry.
    always_comb begin
        w_anyReady  = 1'b0;
        w_selIdx    = '0;
        w_selAge    = '0;
        w_freeFound = 1'b0;
        w_freeIdx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_ready[i] && (!w_anyReady || (age_q[i] > w_selAge))) begin
                w_anyReady = 1'b1;
                w_selIdx   = c_idx_w'(i);
                w_selAge   = age_q[i];
            end
            if (!valid_q[i] && !w_freeFound) begin
                w_freeFound = 1'b1;
                w_freeIdx   = c_idx_w'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        cmd_d   = cmd_q;
        dest_d  = dest_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_hit1[i]) begin
                tag1_d[i] = '0;
                val1_d[i] = cdbVal_i;
            end
            if (w_hit2[i]) begin
                tag2_d[i] = '0;
                val2_d[i] = cdbVal_i;
            end
            if (w_dispatch) begin
                if (w_freeIdx == c_idx_w'(i)) begin
                    age_d[i] = '0;
                end else if (valid_q[i] && (age_q[i] != c_age_max)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
        if (w_load && w_anyReady) begin
            valid_d[w_selIdx] = 1'b0;
        end
        if (w_dispatch) begin
            valid_d[w_freeIdx] = 1'b1;
            cmd_d[w_freeIdx]   = dispatchCommands_i;
            dest_d[w_freeIdx]  = dispatchDestTag_i;
            if (cdbValid_i && (dispatchSrcTag1_i != '0) && (dispatchSrcTag1_i == cdbTag_i)) begin
                tag1_d[w_freeIdx] = '0;
                val1_d[w_freeIdx] = cdbVal_i;
            end else begin
                tag1_d[w_freeIdx] = dispatchSrcTag1_i;
                val1_d[w_freeIdx] = dispatchVal1_i;
            end
            if (cdbValid_i && (dispatchSrcTag2_i != '0) && (dispatchSrcTag2_i == cdbTag_i)) begin
                tag2_d[w_freeIdx] = '0;
                val2_d[w_freeIdx] = cdbVal_i;
            end else begin
                tag2_d[w_freeIdx] = dispatchSrcTag2_i;
                val2_d[w_freeIdx] = dispatchVal2_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i || flush_i) begin
            valid_q     <= '0;
            age_q       <= '{default: '0};
            slotValid_q <= 1'b0;
            slotVal1_q  <= '0;
            slotVal2_q  <= '0;
            slotCmd_q   <= '0;
            slotTag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            if (w_load) begin
                slotValid_q <= w_anyReady;
                if (w_anyReady) begin
                    slotVal1_q <= w_fwd1[w_selIdx];
                    slotVal2_q <= w_fwd2[w_selIdx];
                    slotCmd_q  <= cmd_q[w_selIdx];
                    slotTag_q  <= dest_q[w_selIdx];
                end
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        cmd_q  <= cmd_d;
        dest_q <= dest_d;
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
    end

    assign readyRS_o                    = slotValid_q;
    assign reservationStationVal1_o     = slotVal1_q;
    assign reservationStationVal2_o     = slotVal2_q;
    assign reservationStationCommands_o = slotCmd_q;
    assign reservationStationTag_o      = slotTag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_reservation_station
// Brief    : Scoreboard bench for alu_reservation_station (honours RS_CDB_WAKEUP_EN).
// Revision : 1.0
// ============================================================================
module tb_alu_reservation_station;
    localparam int ROBSIZE = 8;
    localparam int TW      = $clog2(ROBSIZE + 1);
    localparam int DEPTH   = 4;
`ifdef RS_CDB_WAKEUP_EN
    localparam int WAKE_EXTRA = 0;
`else
    localparam int WAKE_EXTRA = 1;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i, flush_i, dispatchValid_i, cdbValid_i, stallRS_i;
    logic [9:0]    dispatchCommands_i;
    logic [TW-1:0] dispatchDestTag_i, dispatchSrcTag1_i, dispatchSrcTag2_i, cdbTag_i;
    logic [63:0]   dispatchVal1_i, dispatchVal2_i, cdbVal_i;
    logic          rsFull_o, readyRS_o;
    logic [63:0]   reservationStationVal1_o, reservationStationVal2_o;
    logic [9:0]    reservationStationCommands_o;
    logic [TW-1:0] reservationStationTag_o;

    typedef struct packed {
        logic [63:0]   v1;
        logic [63:0]   v2;
        logic [9:0]    cmd;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_exp;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_reservation_station #(.ROBsize(ROBSIZE), .RS_DEPTH(DEPTH)) dut (
        .clk_i                        (clk_i),
        .reset_i                      (reset_i),
        .flush_i                      (flush_i),
        .dispatchValid_i              (dispatchValid_i),
        .dispatchCommands_i           (dispatchCommands_i),
        .dispatchDestTag_i            (dispatchDestTag_i),
        .dispatchVal1_i               (dispatchVal1_i),
        .dispatchVal2_i               (dispatchVal2_i),
        .dispatchSrcTag1_i            (dispatchSrcTag1_i),
        .dispatchSrcTag2_i            (dispatchSrcTag2_i),
        .rsFull_o                     (rsFull_o),
        .cdbValid_i                   (cdbValid_i),
        .cdbTag_i                     (cdbTag_i),
        .cdbVal_i                     (cdbVal_i),
        .stallRS_i                    (stallRS_i),
        .reservationStationVal1_o     (reservationStationVal1_o),
        .reservationStationVal2_o     (reservationStationVal2_o),
        .reservationStationCommands_o (reservationStationCommands_o),
        .reservationStationTag_o      (reservationStationTag_o),
        .readyRS_o                    (readyRS_o)
    );

    always #5 clk_i = ~clk_i;

    // Each cycle the execute stage takes the slot (ready and not stalled) is one issue.
    always @(negedge clk_i) begin
        if (reset_i && readyRS_o && !stallRS_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got tag %0d val1 %h, required no issue",
                         reservationStationTag_o, reservationStationVal1_o);
            end else begin
                m_exp = sb_q.pop_front();
                if ({reservationStationVal1_o, reservationStationVal2_o,
                     reservationStationCommands_o, reservationStationTag_o} !== m_exp) begin
                    n_err++;
                    $display("FAIL issue_order: got v1=%h v2=%h cmd=%h tag=%0d, required v1=%h v2=%h cmd=%h tag=%0d",
                             reservationStationVal1_o, reservationStationVal2_o,
                             reservationStationCommands_o, reservationStationTag_o,
                             m_exp.v1, m_exp.v2, m_exp.cmd, m_exp.tag);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_disp(input logic [63:0] v1, input logic [63:0] v2,
                              input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                              input logic [TW-1:0] dest, input logic [9:0] cmd);
        dispatchValid_i    = 1'b1;
        dispatchVal1_i     = v1;
        dispatchVal2_i     = v2;
        dispatchSrcTag1_i  = t1;
        dispatchSrcTag2_i  = t2;
        dispatchDestTag_i  = dest;
        dispatchCommands_i = cmd;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        drive_disp(64'h11, 64'h22, '0, '0, 4'd1, 10'h3);
        step();
        step();
        n_cmp += 6;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", readyRS_o); end
        if (rsFull_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b required 0", rsFull_o); end
        if (reservationStationVal1_o !== 64'h0) begin n_err++; $display("FAIL reset_val1: got %h required 0", reservationStationVal1_o); end
        if (reservationStationVal2_o !== 64'h0) begin n_err++; $display("FAIL reset_val2: got %h required 0", reservationStationVal2_o); end
        if (reservationStationCommands_o !== 10'h0) begin n_err++; $display("FAIL reset_cmd: got %h required 0", reservationStationCommands_o); end
        if (reservationStationTag_o !== '0) begin n_err++; $display("FAIL reset_tag: got %0d required 0", reservationStationTag_o); end
        reset_i = 1'b1;
        dispatchValid_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL reset_dispatch_dropped: got ready %b required 0", readyRS_o); end
    endtask

    task automatic test_ready_dispatch();
        drive_disp(64'd15, 64'd3, '0, '0, 4'd3, 10'd10);
        sb_q.push_back('{64'd15, 64'd3, 10'd10, 4'd3});
        step();
        dispatchValid_i = 1'b0;
        n_cmp++;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL ready_early: got %b required 0", readyRS_o); end
        step();
        n_cmp += 2;
        if (readyRS_o !== 1'b1) begin n_err++; $display("FAIL ready_rise: got %b required 1", readyRS_o); end
        if (reservationStationVal1_o !== 64'd15) begin n_err++; $display("FAIL ready_val1: got %0d required 15", reservationStationVal1_o); end
        step();
        n_cmp++;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL ready_fall: got %b required 0", readyRS_o); end
    endtask

    task automatic test_wakeup();
        drive_disp(64'hDEAD, 64'd7, 4'd5, '0, 4'd2, 10'h0C);
        sb_q.push_back('{64'h20, 64'd7, 10'h0C, 4'd2});
        step();
        dispatchValid_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL wake_premature: got %b required 0", readyRS_o); end
        cdbValid_i = 1'b1;
        cdbTag_i   = 4'd5;
        cdbVal_i   = 64'h20;
        step();
        cdbValid_i = 1'b0;
        for (int k = 0; k < WAKE_EXTRA; k++) begin
            n_cmp++;
            if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL wake_latency: got ready %b required 0", readyRS_o); end
            step();
        end
        n_cmp += 3;
        if (readyRS_o !== 1'b1) begin n_err++; $display("FAIL wake_ready: got %b required 1", readyRS_o); end
        if (reservationStationVal1_o !== 64'h20) begin n_err++; $display("FAIL wake_val1: got %h required 20", reservationStationVal1_o); end
        if (reservationStationTag_o !== 4'd2) begin n_err++; $display("FAIL wake_tag: got %0d required 2", reservationStationTag_o); end
        step();
    endtask

    task automatic test_dispatch_cdb();
        drive_disp(64'h1, 64'h2, 4'd7, 4'd7, 4'd6, 10'h15);
        cdbValid_i = 1'b1;
        cdbTag_i   = 4'd7;
        cdbVal_i   = 64'h77;
        sb_q.push_back('{64'h77, 64'h77, 10'h15, 4'd6});
        step();
        dispatchValid_i = 1'b0;
        cdbValid_i      = 1'b0;
        step();
        n_cmp += 2;
        if (readyRS_o !== 1'b1) begin n_err++; $display("FAIL dcdb_ready: got %b required 1", readyRS_o); end
        if (reservationStationVal2_o !== 64'h77) begin n_err++; $display("FAIL dcdb_val2: got %h required 77", reservationStationVal2_o); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_disp(64'h300 + 64'(i), 64'h400 + 64'(i), '0, '0, TW'(i + 1), 10'h040 + 10'(i));
            sb_q.push_back('{64'h300 + 64'(i), 64'h400 + 64'(i), 10'h040 + 10'(i), TW'(i + 1)});
            step();
        end
        dispatchValid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp += 2;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got ready %b required 0", readyRS_o); end
        if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d outstanding required 0", sb_q.size()); end
    endtask

    task automatic test_oldest_first();
        drive_disp(64'hC1, 64'hC2, '0, '0, 4'd1, 10'h0C1);
        sb_q.push_back('{64'hC1, 64'hC2, 10'h0C1, 4'd1});
        step();
        stallRS_i = 1'b1;
        drive_disp(64'h0, 64'hA2, 4'd4, '0, 4'd7, 10'h0A1);
        step();
        drive_disp(64'hB1, 64'hB2, '0, '0, 4'd8, 10'h0B1);
        step();
        dispatchValid_i = 1'b0;
        cdbValid_i = 1'b1;
        cdbTag_i   = 4'd4;
        cdbVal_i   = 64'h44;
        step();
        cdbValid_i = 1'b0;
        n_cmp++;
        if (reservationStationTag_o !== 4'd1) begin n_err++; $display("FAIL oldest_hold: got tag %0d required 1", reservationStationTag_o); end
        sb_q.push_back('{64'h44, 64'hA2, 10'h0A1, 4'd7});
        sb_q.push_back('{64'hB1, 64'hB2, 10'h0B1, 4'd8});
        stallRS_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp += 2;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL oldest_drain: got ready %b required 0", readyRS_o); end
        if (sb_q.size() != 0) begin n_err++; $display("FAIL oldest_pending: got %0d outstanding required 0", sb_q.size()); end
    endtask

    task automatic test_full_stall();
        logic [63:0] v;
        stallRS_i = 1'b1;
        drive_disp(64'h9999, 64'h8888, '0, '0, 4'd8, 10'h3FF);
        sb_q.push_back('{64'h9999, 64'h8888, 10'h3FF, 4'd8});
        step();
        for (int i = 0; i < DEPTH; i++) begin
            v = {32'h0, $urandom};
            drive_disp(v, 64'h500 + 64'(i), '0, '0, TW'(i + 1), 10'h100 + 10'(i));
            sb_q.push_back('{v, 64'h500 + 64'(i), 10'h100 + 10'(i), TW'(i + 1)});
            step();
        end
        n_cmp++;
        if (rsFull_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b required 1", rsFull_o); end
        drive_disp(64'hBAD, 64'hBAD, '0, '0, 4'd6, 10'h2AA);
        step();
        dispatchValid_i = 1'b0;
        n_cmp += 4;
        if (rsFull_o !== 1'b1) begin n_err++; $display("FAIL full_still: got %b required 1", rsFull_o); end
        if (readyRS_o !== 1'b1) begin n_err++; $display("FAIL full_slot_ready: got %b required 1", readyRS_o); end
        if (reservationStationTag_o !== 4'd8) begin n_err++; $display("FAIL full_slot_tag: got %0d required 8", reservationStationTag_o); end
        if (reservationStationVal1_o !== 64'h9999) begin n_err++; $display("FAIL full_slot_val1: got %h required 9999", reservationStationVal1_o); end
        stallRS_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();
        n_cmp += 3;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL full_drain: got ready %b required 0", readyRS_o); end
        if (rsFull_o !== 1'b0) begin n_err++; $display("FAIL full_clear: got %b required 0", rsFull_o); end
        if (sb_q.size() != 0) begin n_err++; $display("FAIL full_pending: got %0d outstanding required 0", sb_q.size()); end
    endtask

    task automatic test_flush();
        stallRS_i = 1'b1;
        drive_disp(64'hF0, 64'hF1, '0, '0, 4'd1, 10'h0F0);
        step();
        drive_disp(64'h0, 64'hF2, 4'd6, '0, 4'd2, 10'h0F1);
        step();
        drive_disp(64'hF3, 64'hF4, '0, '0, 4'd3, 10'h0F2);
        step();
        drive_disp(64'hF5, 64'hF6, '0, '0, 4'd4, 10'h0F3);
        step();
        n_cmp++;
        if (readyRS_o !== 1'b1) begin n_err++; $display("FAIL flush_pre_slot: got %b required 1", readyRS_o); end
        flush_i = 1'b1;
        drive_disp(64'hF7, 64'hF8, '0, '0, 4'd5, 10'h0F4);
        step();
        flush_i = 1'b0;
        dispatchValid_i = 1'b0;
        stallRS_i = 1'b0;
        n_cmp += 3;
        if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b required 0", readyRS_o); end
        if (rsFull_o !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b required 0", rsFull_o); end
        if (reservationStationTag_o !== '0) begin n_err++; $display("FAIL flush_tag: got %0d required 0", reservationStationTag_o); end
        cdbValid_i = 1'b1;
        cdbTag_i   = 4'd6;
        cdbVal_i   = 64'h66;
        step();
        cdbValid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (readyRS_o !== 1'b0) begin n_err++; $display("FAIL flush_ghost: got ready %b required 0", readyRS_o); end
        end
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; stallRS_i = 1'b0;
        dispatchValid_i = 1'b0; dispatchCommands_i = '0; dispatchDestTag_i = '0;
        dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchSrcTag1_i = '0; dispatchSrcTag2_i = '0;
        cdbValid_i = 1'b0; cdbTag_i = '0; cdbVal_i = '0;
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_dispatch_cdb();
        test_back_to_back();
        test_oldest_first();
        test_full_stall();
        test_flush();
        n_cmp++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL final_pending: got %0d outstanding required 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
